uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter (txuart: i_wr/i_data in, o_busy out) between N byte

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester, txuart and status signals around uart_tx_arbiter.
// master = the requesters/transmitter side, slave = the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]   i_req;
    logic [8*N_REQ-1:0] i_data;
    logic [N_REQ-1:0]   o_ack;
    logic [N_REQ-1:0]   o_grant;
    logic               o_tx_wr;
    logic [7:0]         o_tx_data;
    logic               i_tx_busy;
    logic               o_busy;
    logic               o_timeout;

    modport master (
        output i_req, i_data, i_tx_busy,
        input  o_ack, o_grant, o_tx_wr, o_tx_data, o_busy, o_timeout
    );

    modport slave (
        input  i_req, i_data, i_tx_busy,
        output o_ack, o_grant, o_tx_wr, o_tx_data, o_busy, o_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one txuart between N_REQ byte requesters, round-robin,
// one byte per arbitration, waiting out the transmitter's busy window.
// Define UART_ARB_BURST_EN to let the current owner keep the transmitter for up
// to MAX_BURST consecutive bytes while it still has data pending.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int ACCEPT_TIMEOUT = 16,
    parameter int MAX_BURST      = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);

    if (N_REQ < 2 || N_REQ > 8 || ACCEPT_TIMEOUT < 1 || MAX_BURST < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             wr_q, wr_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       data_q, data_d;

    logic             rr_found;
    logic [PW-1:0]    rr_win;
    logic [PW:0]      rr_sum;
    logic             any_req;
    logic [PW-1:0]    pick;

    // Round-robin search starting just after the last owner, wrapping explicitly.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = ptr_q;
        rr_sum   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            rr_sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (rr_sum >= (PW+1)'(N_REQ))
                rr_sum = rr_sum - (PW+1)'(N_REQ);
            if (!rr_found && bus.i_req[rr_sum[PW-1:0]]) begin
                rr_found = 1'b1;
                rr_win   = rr_sum[PW-1:0];
            end
        end
    end

`ifdef UART_ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [BW-1:0] burst_q, burst_d;
    logic          keep;

    // A zero count means no burst is running, so the first grant after reset or
    // a timeout always goes through round-robin.
    assign keep    = bus.i_req[ptr_q] && (burst_q != '0) && (burst_q < BW'(MAX_BURST));
    assign any_req = keep || rr_found;
    assign pick    = keep ? ptr_q : rr_win;

    // Burst length of the current owner; restarts at one on every hand-over.
    always_comb begin
        burst_d = burst_q;
        if (state_q == IDLE && any_req)
            burst_d = keep ? burst_q + BW'(1) : BW'(1);
        else if (timeout_d)
            burst_d = '0;
    end

    // Burst counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            burst_q <= '0;
        else
            burst_q <= burst_d;
    end
`else
    assign any_req = rr_found;
    assign pick    = rr_win;
`endif

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        to_cnt_d  = to_cnt_q;
        grant_d   = grant_q;
        data_d    = data_q;
        ack_d     = '0;
        wr_d      = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = WAIT_BUSY;
                    ptr_d    = pick;
                    to_cnt_d = '0;
                    ack_d    = N_REQ'(1) << pick;
                    grant_d  = N_REQ'(1) << pick;
                    wr_d     = 1'b1;
                    data_d   = bus.i_data[{pick, 3'b000} +: 8];
                end
            end
            WAIT_BUSY: begin
                if (bus.i_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q == TW'(ACCEPT_TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.i_tx_busy) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers; the pointer starts at the last requester so
    // requester 0 wins the first arbitration.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= PW'(N_REQ - 1);
            to_cnt_q  <= '0;
            ack_q     <= '0;
            grant_q   <= '0;
            wr_q      <= 1'b0;
            timeout_q <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            to_cnt_q  <= to_cnt_d;
            ack_q     <= ack_d;
            grant_q   <= grant_d;
            wr_q      <= wr_d;
            timeout_q <= timeout_d;
            data_q    <= data_d;
        end
    end

    assign bus.o_ack     = ack_q;
    assign bus.o_grant   = grant_q;
    assign bus.o_tx_wr   = wr_q;
    assign bus.o_tx_data = data_q;
    assign bus.o_timeout = timeout_q;
    assign bus.o_busy    = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven arbitration vectors plus directed corner
// sequences, with every o_tx_wr checked against a scoreboard of expected bytes.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int MB = 4;
`ifdef UART_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct packed { logic [3:0] g; logic [7:0] d; } exp_t;
    typedef struct packed { logic [3:0] req; logic [1:0] w; logic [1:0] wb; } vec_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic mon_en = 1'b0;
    logic tx_en  = 1'b1;
    int   busy_dly = 0;
    int   busy_len = 3;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t tab[10];

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .ACCEPT_TIMEOUT(TO), .MAX_BURST(MB)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int w, input logic [31:0] data);
        exp_t e;
        e.g = 4'b0001 << w;
        e.d = data[8*w +: 8];
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_grant"}, 32'(bus.o_grant), 0);
        chk({nm, "_pulses"}, {28'd0, bus.o_ack != 4'd0, bus.o_tx_wr, bus.o_timeout, bus.o_busy}, 0);
        chk({nm, "_data"}, 32'(bus.o_tx_data), 0);
    endtask

    task automatic do_reset();
        bus.i_req = '0;
        rst_n = 1'b0;
        #1;
        chk_zero("rst");
        tick();
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic wait_empty(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            tick();
            n++;
        end
        chk("sb_wait", 32'(sb.size()), 0);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (bus.o_busy && n < max) begin
            tick();
            n++;
        end
        chk("idle_wait", 32'(bus.o_busy), 0);
    endtask

    // Transmitter model: after each write strobe, busy rises after busy_dly
    // cycles and stays high for busy_len cycles.
    initial begin
        bus.i_tx_busy = 1'b0;
        forever begin
            tick();
            if (mon_en && tx_en && bus.o_tx_wr) begin
                repeat (busy_dly) tick();
                bus.i_tx_busy = 1'b1;
                repeat (busy_len) tick();
                bus.i_tx_busy = 1'b0;
            end
        end
    end

    // Scoreboard consumer: every strobe must match the oldest expected byte.
    initial begin
        exp_t e;
        forever begin
            tick();
            if (mon_en && (bus.o_tx_wr !== 1'b0 || bus.o_ack !== 4'd0)) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_wr: got wr=%b ack=%b want no strobe", bus.o_tx_wr, bus.o_ack);
                end else begin
                    e = sb.pop_front();
                    chk("sb_wr", 32'(bus.o_tx_wr), 1);
                    chk("sb_ack", 32'(bus.o_ack), 32'(e.g));
                    chk("sb_grant", 32'(bus.o_grant), 32'(e.g));
                    chk("sb_data", 32'(bus.o_tx_data), 32'(e.d));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          nwr;
        int          n;
        tab[0] = '{4'b1111, 2'd0, 2'd0};
        tab[1] = '{4'b1010, 2'd1, 2'd1};
        tab[2] = '{4'b1010, 2'd3, 2'd1};
        tab[3] = '{4'b0110, 2'd1, 2'd1};
        tab[4] = '{4'b0110, 2'd2, 2'd1};
        tab[5] = '{4'b0001, 2'd0, 2'd0};
        tab[6] = '{4'b0001, 2'd0, 2'd0};
        tab[7] = '{4'b1000, 2'd3, 2'd3};
        tab[8] = '{4'b1100, 2'd2, 2'd3};
        tab[9] = '{4'b1100, 2'd3, 2'd3};
        bus.i_req  = '0;
        bus.i_data = '0;
        tick();
        do_reset();

        busy_dly = 0;
        busy_len = 3;
        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(16 * v + k);
            bus.i_data = d;
            bus.i_req  = tab[v].req;
            push(BURST ? int'(tab[v].wb) : int'(tab[v].w), d);
            wait_empty(20);
            bus.i_req = '0;
            wait_idle(40);
        end

        do_reset();
        busy_len   = 10;
        d          = 32'hD3C2B1A0;
        bus.i_data = d;
        bus.i_req  = 4'b1111;
        for (int i = 0; i < 8; i++) push(BURST ? i / 4 : i % 4, d);
        wait_empty(200);
        bus.i_req = '0;
        wait_idle(40);

        do_reset();
        busy_dly   = 1;
        busy_len   = 20;
        d          = 32'h00A5_0000;
        bus.i_data = d;
        bus.i_req  = 4'b0100;
        push(2, d);
        tick();
        chk("single_lat_wr", 32'(bus.o_tx_wr), 1);
        bus.i_req = '0;
        n = 0;
        while (bus.o_grant == 4'b0100 && n < 60) begin
            n++;
            tick();
        end
        chk("single_grant_hold", 32'(n), 22);
        chk("single_grant_clr", 32'(bus.o_grant), 0);
        chk("single_busy_clr", 32'(bus.o_busy), 0);

        do_reset();
        busy_dly   = 0;
        tx_en      = 1'b0;
        d          = 32'h4433_2211;
        bus.i_data = d;
        bus.i_req  = 4'b0011;
        push(0, d);
        tick();
        chk("to_wr", 32'(bus.o_tx_wr), 1);
        bus.i_req = 4'b0010;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.o_timeout && n < 40);
        chk("to_latency", 32'(n), TO);
        chk("to_grant", 32'(bus.o_grant), 0);
        chk("to_busy", 32'(bus.o_busy), 0);
        push(1, d);
        tick();
        chk("to_next_wr", 32'(bus.o_tx_wr), 1);
        chk("to_pulse_len", 32'(bus.o_timeout), 0);
        bus.i_req = '0;
        wait_idle(40);
        tx_en = 1'b1;

        do_reset();
        busy_len   = 10;
        d          = 32'h9900_0088;
        bus.i_data = d;
        bus.i_req  = 4'b1001;
        push(0, d);
        tick();
        tick();
        tick();
        tick();
        chk("mid_rst_in_wait", 32'(bus.o_busy), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        tick();
        rst_n = 1'b1;
        push(0, d);
        tick();
        chk("mid_rst_rel_wr", 32'(bus.o_tx_wr), 1);
        bus.i_req = '0;
        wait_idle(40);

        do_reset();
        busy_len   = 8;
        d          = 32'h0000_7766;
        bus.i_data = d;
        bus.i_req  = 4'b0011;
        push(0, d);
        tick();
        chk("drop_wr", 32'(bus.o_tx_wr), 1);
        bus.i_req = '0;
        nwr = 0;
        repeat (30) begin
            tick();
            if (bus.o_tx_wr) nwr++;
        end
        chk("drop_no_wr", 32'(nwr), 0);

        do_reset();
        busy_len   = 2;
        d          = 32'h0000_C3B2;
        bus.i_data = d;
        bus.i_req  = 4'b0011;
        for (int i = 0; i < 8; i++) push(BURST ? (i / 4) % 2 : i % 2, d);
        wait_empty(200);
        bus.i_req = '0;
        wait_idle(40);

        chk("sb_drain", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
